// File: rtl/multicycle_ctrl.sv
// Moore control FSM sequencing a multi-cycle MIPS datapath (shared memory, IR, A/B/ALUOut, one ALU).
// Optional feature macro MC_TIMEOUT_EN: bounds every memory wait to TIMEOUT_CYCLES and pulses mem_timeout.
module multicycle_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_timeout
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_RD    = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WR    = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    ADDI_EXEC = 4'd10,
    ADDI_WB   = 4'd11
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
    logic       mem_timeout;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  if (2 ** CNT_W <= TIMEOUT_CYCLES) begin : g_cfg_check
    $error("CNT_W is too narrow to count to TIMEOUT_CYCLES");
  end

  state_t state_q, state_d;
  ctrl_t  ctrl, ctrl_gated;
  logic   timeout;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

`ifdef MC_TIMEOUT_EN
  logic [CNT_W-1:0] wait_cnt;
  logic             waiting;

  assign waiting = (state_q == FETCH || state_q == MEM_RD || state_q == MEM_WR) && !mem_ready;
  assign timeout = waiting && (wait_cnt == CNT_W'(TIMEOUT_CYCLES));

  // Any state change out of a wait state implies mem_ready or timeout, both of which clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   wait_cnt <= '0;
    else if (waiting && !timeout) wait_cnt <= wait_cnt + 1'b1;
    else                          wait_cnt <= '0;
  end
`else
  assign timeout = 1'b0;
`endif

  // NOTE: every comb output gets a default first, so no path leaves a latch behind.
  always_comb begin
    ctrl    = '0;
    state_d = FETCH;
    unique case (state_q)
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = 2'b01;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
        state_d        = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        ctrl.alu_src_b = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = MEM_ADDR;
          OP_RTYPE:     state_d = R_EXEC;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          OP_ADDI:      state_d = ADDI_EXEC;
          default: begin
            ctrl.illegal_op = 1'b1;
            ctrl.instr_done = 1'b1;
            state_d         = FETCH;
          end
        endcase
      end
      MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        state_d        = (op == OP_SW) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
        if (mem_ready)    state_d = MEM_WB;
        else if (timeout) state_d = FETCH;
        else              state_d = MEM_RD;
      end
      MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      MEM_WR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.i_or_d     = 1'b1;
        ctrl.instr_done = mem_ready;
        state_d         = (mem_ready || timeout) ? FETCH : MEM_WR;
      end
      R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = 2'b10;
        state_d        = R_WB;
      end
      R_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = 2'b01;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = 2'b01;
        ctrl.instr_done    = 1'b1;
      end
      JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = 2'b10;
        ctrl.instr_done = 1'b1;
      end
      ADDI_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        state_d        = ADDI_WB;
      end
      ADDI_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: state_d = FETCH;
    endcase
    ctrl.mem_timeout = timeout;
  end

  // Reset must silence the FETCH strobes immediately, not just at the next edge.
  assign ctrl_gated = rst_n ? ctrl : '0;

  assign pc_write      = ctrl_gated.pc_write;
  assign pc_write_cond = ctrl_gated.pc_write_cond;
  assign i_or_d        = ctrl_gated.i_or_d;
  assign mem_read      = ctrl_gated.mem_read;
  assign mem_write     = ctrl_gated.mem_write;
  assign ir_write      = ctrl_gated.ir_write;
  assign mem_to_reg    = ctrl_gated.mem_to_reg;
  assign reg_dst       = ctrl_gated.reg_dst;
  assign reg_write     = ctrl_gated.reg_write;
  assign alu_src_a     = ctrl_gated.alu_src_a;
  assign alu_src_b     = ctrl_gated.alu_src_b;
  assign alu_op        = ctrl_gated.alu_op;
  assign pc_source     = ctrl_gated.pc_source;
  assign instr_done    = ctrl_gated.instr_done;
  assign illegal_op    = ctrl_gated.illegal_op;
  assign mem_timeout   = ctrl_gated.mem_timeout;
  assign state         = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-instruction state paths expand into expected per-cycle outputs.
module tb_multicycle_ctrl;

`ifdef MC_TIMEOUT_EN
  localparam int TMO    = 4;
  localparam bit TMO_EN = 1'b1;
`else
  localparam int TMO    = 255;
  localparam bit TMO_EN = 1'b0;
`endif

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  typedef struct packed {
    logic [3:0] state;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
    logic       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       instr_done, illegal_op, mem_timeout;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op = '0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;
  logic       instr_done, illegal_op, mem_timeout;

  multicycle_ctrl #(.TIMEOUT_CYCLES(TMO), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state(state), .instr_done(instr_done),
    .illegal_op(illegal_op), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  obs_t act;
  assign act = {state, pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                alu_src_b, alu_op, pc_source, instr_done, illegal_op, mem_timeout};

  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;
  obs_t exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] o);
    return o inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
  endfunction

  // Output table of each state as the datapath needs it; mr is that cycle's mem_ready.
  function automatic obs_t spec_out(input int s, input bit mr, input logic [5:0] o, input bit tmo);
    obs_t e = '0;
    e.state = 4'(s);
    case (s)
      0:  begin e.mem_read = 1; e.alu_src_b = 2'b01; e.ir_write = mr; e.pc_write = mr; end
      1:  begin e.alu_src_b = 2'b11; e.illegal_op = !is_legal(o); e.instr_done = !is_legal(o); end
      2:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      3:  begin e.mem_read = 1; e.i_or_d = 1; end
      4:  begin e.reg_write = 1; e.mem_to_reg = 1; e.instr_done = 1; end
      5:  begin e.mem_write = 1; e.i_or_d = 1; e.instr_done = mr; end
      6:  begin e.alu_src_a = 1; e.alu_op = 2'b10; end
      7:  begin e.reg_write = 1; e.reg_dst = 1; e.instr_done = 1; end
      8:  begin e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_write_cond = 1; e.pc_source = 2'b01; e.instr_done = 1; end
      9:  begin e.pc_write = 1; e.pc_source = 2'b10; e.instr_done = 1; end
      10: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      11: begin e.reg_write = 1; e.instr_done = 1; end
      default: ;
    endcase
    e.mem_timeout = tmo;
    return e;
  endfunction

  // One clock cycle: drive inputs just after the edge and queue the expected response.
  task automatic step(input int s, input bit mr, input logic [5:0] o_drv, input logic [5:0] o_mdl, input bit tmo);
    op        = o_drv;
    mem_ready = mr;
    exp_q.push_back(spec_out(s, mr, o_mdl, tmo));
    @(posedge clk);
    #1;
  endtask

  // A memory wait: w cycles without mem_ready, cut short by the timeout when enabled.
  task automatic wait_state(input int s, input int w, input logic [5:0] o, output bit aborted);
    aborted = 1'b0;
    for (int k = 0; k <= w; k++) begin
      bit mr = (k >= w);
      bit t  = TMO_EN && !mr && (k == TMO);
      step(s, mr, (s == 0) ? 6'($urandom) : o, o, t);
      if (t) begin
        aborted = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_instr(input logic [5:0] o, input int wf, input int wm);
    bit ab;
    wait_state(0, wf, o, ab);
    if (ab) return;
    step(1, 1'($urandom), o, o, 1'b0);
    case (o)
      OP_LW: begin
        step(2, 1'($urandom), o, o, 1'b0);
        wait_state(3, wm, o, ab);
        if (!ab) step(4, 1'($urandom), o, o, 1'b0);
      end
      OP_SW: begin
        step(2, 1'($urandom), o, o, 1'b0);
        wait_state(5, wm, o, ab);
      end
      OP_R:    begin step(6, 1'($urandom), o, o, 1'b0); step(7, 1'($urandom), o, o, 1'b0); end
      OP_BEQ:  step(8, 1'($urandom), o, o, 1'b0);
      OP_J:    step(9, 1'($urandom), o, o, 1'b0);
      OP_ADDI: begin step(10, 1'($urandom), o, o, 1'b0); step(11, 1'($urandom), o, o, 1'b0); end
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_underflow", 32'd1, 32'd0);
      end else begin
        obs_t e;
        e = exp_q.pop_front();
        check($sformatf("cycle_state%0d", e.state), 32'(act), 32'(e));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] legal_ops [6] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
    logic [5:0] o;

    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'(act), 32'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    run_instr(OP_R,    0, 0);
    run_instr(OP_LW,   2, 2);
    run_instr(OP_SW,   0, 2);
    run_instr(OP_BEQ,  0, 0);
    run_instr(6'h3F,   0, 0);
    run_instr(OP_J,    0, 0);
    run_instr(OP_ADDI, 1, 0);
    run_instr(OP_LW,   0, TMO_EN ? TMO + 2 : 6);
    run_instr(OP_LW,   0, TMO_EN ? TMO : 3);
    run_instr(OP_SW,   TMO_EN ? TMO + 1 : 5, 1);

    // Asynchronous reset taken in the middle of a memory read.
    step(0, 1'b1, OP_LW, OP_LW, 1'b0);
    step(1, 1'b0, OP_LW, OP_LW, 1'b0);
    step(2, 1'b0, OP_LW, OP_LW, 1'b0);
    step(3, 1'b0, OP_LW, OP_LW, 1'b0);
    mon_en = 1'b0;
    exp_q.delete();
    #2 rst_n = 1'b0;
    #1 check("async_reset_mid_mem_rd", 32'(act), 32'd0);
    @(posedge clk);
    #1 check("reset_held_over_edge", 32'(act), 32'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    run_instr(OP_LW, 0, 0);

    for (int n = 0; n < 200; n++) begin
      o = ($urandom_range(0, 4) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 5)];
      run_instr(o, ($urandom_range(0, 2) == 0) ? $urandom_range(0, 6) : 0,
                   ($urandom_range(0, 2) == 0) ? $urandom_range(0, 6) : 0);
    end

    mon_en = 1'b0;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore-style control FSM that sequences a multi-cycle MIPS datapath: shared instruction/data memory, IR, A/B/ALUOut registers, single ALU.
- Replaces the single-cycle combinational decoder.
- Decodes opcode per state, handles a memory ready handshake and flags illegal opcodes.
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles a memory state waits for mem_ready (used only with MC_TIMEOUT_EN).
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op  in  6  IR[31:26], valid from DECODE onward.
- mem_ready  in  1  memory completes current access this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load qualified externally by ALU zero.
- i_or_d  out  1  memory address select: 0=PC, 1=ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  IR load.
- mem_to_reg  out  1  RF write data select: 0=ALUOut, 1=MDR.
- reg_dst  out  1  RF dest select: 0=rt, 1=rd.
- reg_write  out  1  RF write enable.
- alu_src_a  out  1  ALU A select: 0=PC, 1=A reg.
- alu_src_b  out  2  ALU B select: 00=B, 01=const 4, 10=sign-ext imm, 11=imm<<2.
- alu_op  out  2  00=add, 01=sub, 10=use funct.
- pc_source  out  2  PC next select: 00=ALU result, 01=ALUOut, 10={PC[31:28],IR[25:0],00}.
- state  out  4  current state encoding, for debug.
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction.
- illegal_op  out  1  one-cycle pulse when DECODE sees an unsupported opcode.
- mem_timeout  out  1  one-cycle pulse when a wait is aborted (MC_TIMEOUT_EN only; otherwise tied 0).

Behaviour:
- Single clock clk. Reset rst_n is asynchronous and active-low.
- While rst_n=0: state=FETCH(0), wait counter=0, every output 0 (state reads 0).
- First cycle after rst_n deasserts: FETCH strobes assert.
- All outputs are combinational from the registered state. pc_write and ir_write are additionally gated by mem_ready.
- Unlisted outputs are 0 in each state.
- FETCH(0): mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. ir_write=pc_write=mem_ready. Stay until mem_ready=1, then go to DECODE.
- DECODE(1): alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state by op:
  - lw/sw -> MEM_ADDR
  - R-type -> R_EXEC
  - beq -> BRANCH
  - j -> JUMP
  - addi -> ADDI_EXEC
  - any other op -> FETCH, with illegal_op=1 and instr_done=1.
- MEM_ADDR(2): alu_src_a=1, alu_src_b=10, alu_op=00. lw -> MEM_RD; sw -> MEM_WR.
- MEM_RD(3): mem_read=1, i_or_d=1. Stay until mem_ready, then go to MEM_WB.
- MEM_WB(4): reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. -> FETCH.
- MEM_WR(5): mem_write=1, i_or_d=1. Hold until mem_ready. instr_done=mem_ready. -> FETCH on mem_ready.
- R_EXEC(6): alu_src_a=1, alu_src_b=00, alu_op=10. -> R_WB.
- R_WB(7): reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. -> FETCH.
- BRANCH(8): alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1. -> FETCH.
- JUMP(9): pc_write=1, pc_source=10, instr_done=1. -> FETCH.
- ADDI_EXEC(10): alu_src_a=1, alu_src_b=10, alu_op=00. -> ADDI_WB.
- ADDI_WB(11): reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. -> FETCH.
- Encodings 12..15 are unreachable; if entered, go to FETCH next cycle with all outputs 0.
- mem_ready is ignored outside FETCH, MEM_RD and MEM_WR.
- Cycle counts with mem_ready held at 1:
  - R-type 4, lw 5, sw 4, beq 3, j 3, addi 4, illegal 2.
  - Each wait cycle adds 1.
- Reset asserted mid-instruction: immediate return to FETCH. A partial write may already have been issued; the controller does not retry it.

Optional Feature:
- Macro: MC_TIMEOUT_EN.
- Defined:
  - Wait counter increments each cycle in FETCH, MEM_RD or MEM_WR with mem_ready=0.
  - Counter clears on state change or when mem_ready=1.
  - When the counter reaches TIMEOUT_CYCLES with mem_ready still 0: mem_timeout=1 for that cycle, next state FETCH, counter cleared. No reg_write, pc_write or ir_write occurs.
  - mem_ready=1 in the same cycle as the limit takes priority: normal completion, no timeout.
- Undefined: no counter is instantiated, waits are unbounded, and mem_timeout is tied to 0.

Test Plan:
- Reset: rst_n=0 mid-MEM_RD -> state=0 and all outputs 0 asynchronously. After release, mem_read=1 on the next cycle.
- R-type with mem_ready=1: op=000000 -> state sequence 0,1,6,7,0. alu_op=10 in state 6. reg_write=1, reg_dst=1 in state 7. instr_done pulses once.
- lw with 3-cycle memory latency on both accesses: op=100011, mem_ready low for 2 cycles in FETCH and in MEM_RD -> total 9 cycles. ir_write and pc_write high only in the mem_ready cycle. reg_write=1 with mem_to_reg=1 in state 4.
- sw then beq: op=101011 -> mem_write held until mem_ready, no reg_write. Then op=000100 -> state 8 with pc_write_cond=1, pc_source=01, alu_op=01.
- Illegal and jump: op=111111 -> illegal_op pulse in state 1, back to 0 in 2 cycles. Then op=000010 -> state 9 with pc_write=1, pc_source=10.
- Timeout (MC_TIMEOUT_EN, TIMEOUT_CYCLES=4): mem_ready=0 in MEM_RD -> mem_timeout pulses 4 cycles after entry, then FETCH, no reg_write. Repeat with mem_ready=1 on the limit cycle -> normal MEM_WB.
